// File: rtl/obi_mem_arbiter.sv
// Two-to-one OBI arbiter: round-robin between Ibex instr/data ports onto one memory slave,
// responses routed in order through an ID FIFO. Optional grant counters: MEM_ARB_STATS_EN.
module obi_mem_arbiter #(
    parameter int unsigned MAX_OUTST = 2,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_req_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    input  logic [ADDR_W-1:0] instr_addr_i,
    input  logic              data_req_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    input  logic              data_we_i,
    input  logic [3:0]        data_be_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [31:0]       data_wdata_i,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_err_i
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_instr_cnt_o,
    output logic [31:0]       stat_data_cnt_o
`endif
);

    localparam int unsigned CntW = $clog2(MAX_OUTST + 1);
    localparam int unsigned PtrW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_OUTST);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_OUTST - 1);

    // ID FIFO entries: 1 = data port, 0 = instruction port
    logic [MAX_OUTST-1:0] id_q;
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      count_q, count_d;
    logic                 lock_q, lock_id_q, last_q;

    logic any_req, win_data, push, pop, head_data;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        any_req = instr_req_i | data_req_i;
        if (lock_q) begin
            win_data = lock_id_q;
        end else if (instr_req_i && data_req_i) begin
            win_data = ~last_q;
        end else begin
            win_data = data_req_i;
        end

        // A response this cycle frees a slot, so a full FIFO can still take a push
        mem_req_o = any_req & ((count_q < MaxCnt) | mem_rvalid_i);
        push      = mem_req_o & mem_gnt_i;
        pop       = mem_rvalid_i & (count_q != '0);
        head_data = id_q[rd_ptr_q];

        instr_gnt_o    = push & ~win_data;
        data_gnt_o     = push & win_data;
        instr_rvalid_o = pop & ~head_data;
        data_rvalid_o  = pop & head_data;
        rdata_o        = mem_rdata_i;
        err_o          = mem_err_i;

        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (any_req) begin
            if (win_data) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_be_o   = 4'hF;
                mem_addr_o = instr_addr_i;
            end
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_q      <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                id_q[wr_ptr_q] <= win_data;
                wr_ptr_q       <= ptr_inc(wr_ptr_q);
                last_q         <= win_data;
                lock_q         <= 1'b0;
            end else if (mem_req_o) begin
                // Request stalled by the slave: hold this winner until its grant
                lock_q    <= 1'b1;
                lock_id_q <= win_data;
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_instr_q, stat_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_instr_q <= '0;
            stat_data_q  <= '0;
        end else begin
            if (instr_gnt_o) stat_instr_q <= stat_instr_q + 32'd1;
            if (data_gnt_o)  stat_data_q  <= stat_data_q + 32'd1;
        end
    end

    assign stat_instr_cnt_o = stat_instr_q;
    assign stat_data_cnt_o  = stat_data_q;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(mem_rvalid_i && count_q == '0))
            else $warning("obi_mem_arbiter: response with no outstanding transaction dropped");
        end
    end
`endif

endmodule
